// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared constants and types for the TPU result byte path
package tpu_pkg;

    localparam int RESULT_W        = 16;
    localparam int NUM_RESULTS     = 4;
    localparam int BYTES_PER_FRAME = 8;
    localparam int FRAME_W         = RESULT_W * NUM_RESULTS;
    localparam int IDX_W           = 3;

    // Byte position within a 16-bit word on the wire: high byte first.
    localparam int HI = 0;
    localparam int LO = 1;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_FULL    = 1'b1
    } stage_state_t;

    function automatic logic [RESULT_W-1:0] join_word(input logic [7:0] hi_byte,
                                                      input logic [7:0] lo_byte);
        return {hi_byte, lo_byte};
    endfunction

endpackage

// File: rtl/result_out_reg.sv
// rtl/result_out_reg.sv - output frame register with valid/ready and load-from-staging
module result_out_reg
    import tpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic [FRAME_W-1:0] i_frame,
    input  logic               i_ready,
    output logic               o_valid,
    output logic [FRAME_W-1:0] o_frame
);

    logic               r_valid;
    logic [FRAME_W-1:0] r_frame;

    // A load in the same cycle as a take keeps valid high with the new frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_frame <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_frame <= i_frame;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_frame = r_frame;

endmodule

// File: rtl/result_collector.sv
// rtl/result_collector.sv - reassembles the 8-byte TPU result frame into four signed words
module result_collector
    import tpu_pkg::*;
#(
    parameter bit REQUIRE_SOF = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [7:0]          in_data,
    input  logic                in_sof,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [RESULT_W-1:0] out_c00,
    output logic [RESULT_W-1:0] out_c01,
    output logic [RESULT_W-1:0] out_c10,
    output logic [RESULT_W-1:0] out_c11,
    output logic                frame_err,
    input  logic                err_clr
);

    logic [1:0]         r_rst_sync;
    logic               w_rst_n;

    stage_state_t       r_state;
    logic               r_in_ready;
    logic [IDX_W-1:0]   r_idx;
    logic [7:0]         r_stage [BYTES_PER_FRAME];
    logic               r_frame_err;

    logic               w_accept;
    logic               w_resync;
    logic               w_drop;
    logic               w_store;
    logic               w_last;
    logic               w_out_free;
    logic               w_load;
    logic               w_out_valid;
    logic [7:0]         w_bytes [BYTES_PER_FRAME];
    logic [FRAME_W-1:0] w_frame;
    logic [FRAME_W-1:0] w_out_frame;

    // Reset asserts asynchronously but releases two clocks later, in step with clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    assign w_accept   = in_valid && r_in_ready;
    assign w_resync   = w_accept && in_sof && (r_idx != '0);
    assign w_drop     = w_accept && REQUIRE_SOF && (r_idx == '0) && !in_sof;
    assign w_store    = w_accept && !w_resync && !w_drop;
    assign w_last     = w_store && (r_idx == IDX_W'(BYTES_PER_FRAME - 1));
    assign w_out_free = !w_out_valid || out_ready;
    assign w_load     = (r_state == ST_COLLECT) ? (w_last && w_out_free)
                                                : (w_out_valid && out_ready);

    // In COLLECT the final byte is still on in_data, so it bypasses staging.
    always_comb begin
        for (int i = 0; i < BYTES_PER_FRAME; i++) begin
            w_bytes[i] = r_stage[i];
        end
        if (r_state == ST_COLLECT) begin
            w_bytes[BYTES_PER_FRAME-1] = in_data;
        end
        w_frame = '0;
        for (int k = 0; k < NUM_RESULTS; k++) begin
            w_frame[k*RESULT_W +: RESULT_W] = join_word(w_bytes[2*k+HI], w_bytes[2*k+LO]);
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state     <= ST_COLLECT;
            r_in_ready  <= 1'b0;
            r_idx       <= '0;
            r_frame_err <= 1'b0;
            for (int i = 0; i < BYTES_PER_FRAME; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            if (w_resync || w_drop) begin
                r_frame_err <= 1'b1;
            end else if (err_clr) begin
                r_frame_err <= 1'b0;
            end

            if (r_state == ST_COLLECT) begin
                r_in_ready <= 1'b1;
                if (w_resync) begin
                    r_stage[0] <= in_data;
                    r_idx      <= IDX_W'(1);
                end else if (w_store) begin
                    r_stage[r_idx] <= in_data;
                    r_idx          <= r_idx + IDX_W'(1);
                    if (w_last && !w_out_free) begin
                        r_state    <= ST_FULL;
                        r_in_ready <= 1'b0;
                    end
                end
            end else begin
                if (w_out_valid && out_ready) begin
                    r_state    <= ST_COLLECT;
                    r_in_ready <= 1'b1;
                    r_idx      <= '0;
                end
            end
        end
    end

    result_out_reg u_out_reg (
        .clk     (clk),
        .rst_n   (w_rst_n),
        .i_load  (w_load),
        .i_frame (w_frame),
        .i_ready (out_ready),
        .o_valid (w_out_valid),
        .o_frame (w_out_frame)
    );

    assign in_ready  = r_in_ready;
    assign out_valid = w_out_valid;
    assign frame_err = r_frame_err;
    assign out_c00   = w_out_frame[0*RESULT_W +: RESULT_W];
    assign out_c01   = w_out_frame[1*RESULT_W +: RESULT_W];
    assign out_c10   = w_out_frame[2*RESULT_W +: RESULT_W];
    assign out_c11   = w_out_frame[3*RESULT_W +: RESULT_W];

endmodule

// File: tb/tb_result_collector.sv
// tb/tb_result_collector.sv - randomized self-checking bench for result_collector
module tb_result_collector;

    logic        clk;
    logic        rst_n;
    logic        in_valid, in_ready, in_sof, out_valid, out_ready, frame_err, err_clr;
    logic [7:0]  in_data;
    logic [15:0] out_c00, out_c01, out_c10, out_c11;

    logic        in_valid0, in_ready0, in_sof0, out_valid0, out_ready0, frame_err0, err_clr0;
    logic [7:0]  in_data0;
    logic [15:0] c0_00, c0_01, c0_10, c0_11;

    int          n_checks;
    int          n_fail;
    logic [7:0]  part_q [$];
    logic [63:0] exp_q  [$];
    logic        model_err;
    logic        hold_prev;
    logic [63:0] prev_frame;
    logic        rnd_ready_en;

    result_collector dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sof(in_sof),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_c00(out_c00), .out_c01(out_c01), .out_c10(out_c10), .out_c11(out_c11),
        .frame_err(frame_err), .err_clr(err_clr)
    );

    result_collector #(.REQUIRE_SOF(1'b0)) dut_nosof (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0), .in_sof(in_sof0),
        .out_valid(out_valid0), .out_ready(out_ready0),
        .out_c00(c0_00), .out_c01(c0_01), .out_c10(c0_10), .out_c11(c0_11),
        .frame_err(frame_err0), .err_clr(err_clr0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Frame-level reference: bytes accumulate in a list; 8 of them make four words.
    task automatic model_accept(input logic [7:0] d, input logic s);
        logic [63:0] f;
        if (s && part_q.size() != 0) begin
            model_err = 1'b1;
            part_q.delete();
            part_q.push_back(d);
        end else if (!s && part_q.size() == 0) begin
            model_err = 1'b1;
        end else begin
            part_q.push_back(d);
            if (part_q.size() == 8) begin
                f = '0;
                for (int k = 0; k < 4; k++) begin
                    f[k*16 +: 16] = {part_q[2*k], part_q[2*k+1]};
                end
                exp_q.push_back(f);
                part_q.delete();
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic s);
        logic got;
        got = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = s;
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge clk);
            if (in_ready) begin
                model_accept(d, s);
                got = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
        if (!got) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_frame(input logic [63:0] fb);
        for (int i = 0; i < 8; i++) begin
            send_byte(fb[63-8*i -: 8], i == 0);
        end
    endtask

    task automatic wait_ready(input string tag);
        logic got;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(posedge clk);
            #1;
            if (in_ready) got = 1'b1;
        end
        chk(tag, {63'd0, got}, 64'd1);
    endtask

    task automatic clr_err(input string tag);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr   = 1'b0;
        model_err = 1'b0;
        chk(tag, {63'd0, frame_err}, 64'd0);
    endtask

    always @(negedge clk) begin
        logic [63:0] f;
        if (rst_n) begin
            if (hold_prev && out_valid)
                chk("hold_stable", {out_c11, out_c10, out_c01, out_c00}, prev_frame);
            if (out_valid && out_ready) begin
                chk("frame_expected", (exp_q.size() != 0) ? 64'd1 : 64'd0, 64'd1);
                if (exp_q.size() != 0) begin
                    f = exp_q.pop_front();
                    chk("c00", {48'd0, out_c00}, {48'd0, f[15:0]});
                    chk("c01", {48'd0, out_c01}, {48'd0, f[31:16]});
                    chk("c10", {48'd0, out_c10}, {48'd0, f[47:32]});
                    chk("c11", {48'd0, out_c11}, {48'd0, f[63:48]});
                end
            end
            hold_prev  = out_valid && !out_ready;
            prev_frame = {out_c11, out_c10, out_c01, out_c00};
        end else begin
            hold_prev = 1'b0;
        end
    end

    always @(posedge clk) begin
        #2;
        if (rnd_ready_en) out_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        logic [63:0] f0;
        logic        s;
        n_checks = 0; n_fail = 0; model_err = 1'b0; hold_prev = 1'b0; rnd_ready_en = 1'b0;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sof = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
        in_valid0 = 1'b0; in_data0 = '0; in_sof0 = 1'b0; out_ready0 = 1'b1; err_clr0 = 1'b0;
        prev_frame = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_c_all", {out_c11, out_c10, out_c01, out_c00}, 64'd0);
        chk("rst_frame_err", {63'd0, frame_err}, 64'd0);
        rst_n = 1'b1;
        wait_ready("ready_after_reset");

        // Known-value frame: latency of one edge after byte 7.
        send_frame(64'h1234_FFFE_0005_8000);
        chk("lat_valid", {63'd0, out_valid}, 64'd1);
        chk("lat_c00", {48'd0, out_c00}, 64'h1234);
        chk("lat_c01", {48'd0, out_c01}, 64'hFFFE);
        chk("lat_c10", {48'd0, out_c10}, 64'h0005);
        chk("lat_c11", {48'd0, out_c11}, 64'h8000);
        repeat (2) @(posedge clk);
        #1;

        // Double buffering: frame 1 held, frame 2 parked in staging.
        out_ready = 1'b0;
        send_frame(64'h0102_0304_0506_0708);
        send_frame(64'h1112_1314_1516_1718);
        chk("full_in_ready", {63'd0, in_ready}, 64'd0);
        fork
            send_frame(64'hA1B2_C3D4_E5F6_0789);
        join_none
        repeat (3) @(posedge clk);
        #2;
        chk("full_stall", {63'd0, in_ready}, 64'd0);
        chk("held_c00", {48'd0, out_c00}, 64'h0102);
        out_ready = 1'b1;
        @(posedge clk);
        #2;
        out_ready = 1'b0;
        chk("release_ready", {63'd0, in_ready}, 64'd1);
        chk("frame2_c00", {48'd0, out_c00}, 64'h1112);
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        wait fork;
        repeat (3) @(posedge clk);
        #1;

        // Resync at idx 3 then a clean frame; only the clean frame emerges.
        send_byte(8'h55, 1'b1);
        send_byte(8'h66, 1'b0);
        send_byte(8'h77, 1'b0);
        send_frame(64'h7FFF_8001_0000_FFFF);
        chk("resync_err", {63'd0, frame_err}, 64'd1);
        clr_err("resync_clr");

        // Missing SOF at idx 0 is dropped.
        send_byte(8'hAA, 1'b0);
        chk("nosof_err", {63'd0, frame_err}, 64'd1);
        chk("nosof_ready", {63'd0, in_ready}, 64'd1);
        send_frame(64'h0011_2233_4455_6677);
        clr_err("nosof_clr");

        // Same stimulus on the REQUIRE_SOF=0 instance is simply accepted.
        f0 = 64'hAA01_0203_0405_0607;
        chk("nosof0_ready", {63'd0, in_ready0}, 64'd1);
        for (int i = 0; i < 8; i++) begin
            in_valid0 = 1'b1;
            in_data0  = f0[63-8*i -: 8];
            in_sof0   = 1'b0;
            @(posedge clk);
            #1;
        end
        in_valid0 = 1'b0;
        chk("nosof0_valid", {63'd0, out_valid0}, 64'd1);
        chk("nosof0_frame", {c0_00, c0_01, c0_10, c0_11}, f0);
        chk("nosof0_err", {63'd0, frame_err0}, 64'd0);

        // Set and clear in the same cycle: set wins.
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b0);
        err_clr = 1'b1;
        send_byte(8'h03, 1'b1);
        err_clr = 1'b0;
        chk("set_beats_clr", {63'd0, frame_err}, 64'd1);
        for (int i = 1; i < 8; i++) send_byte(8'(i * 16 + 3), 1'b0);
        clr_err("setclr_clr");

        // Reset in the middle of a frame.
        for (int i = 0; i < 6; i++) send_byte(8'(8'hC0 + i), i == 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_c", {out_c11, out_c10, out_c01, out_c00}, 64'd0);
        part_q.delete();
        exp_q.delete();
        model_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_ready("ready_after_midrst");
        chk("midrst_valid_after", {63'd0, out_valid}, 64'd0);
        send_frame(64'h8000_7FFF_FF00_00FF);
        repeat (2) @(posedge clk);
        #1;

        // Random stream with random back-pressure and occasional SOF faults.
        rnd_ready_en = 1'b1;
        for (int i = 0; i < 240; i++) begin
            s = (i % 8 == 0);
            if ($urandom_range(0, 19) == 0) s = ~s;
            send_byte(8'($urandom_range(0, 255)), s);
        end
        @(posedge clk);
        #1;
        rnd_ready_en = 1'b0;
        out_ready    = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        chk("rand_err", {63'd0, frame_err}, {63'd0, model_err});

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/result_collector.md
# result_collector

Receive side of the TPU result byte stream. Accepts the 8-byte frame the core emits (c00, c01, c10, c11, each high byte then low byte), reassembles four signed 16-bit results and presents them as one word-parallel transaction with valid/ready handshaking. Sits between the core's 8-bit output pins and the host-side result consumer. Double-buffers: a staging frame can complete while the previous result waits for the consumer.

## Interface
Parameters:
- REQUIRE_SOF, default 1: when 1, a first byte without in_sof is dropped and flagged; when 0, it is accepted as byte 0.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  in_data holds a byte.
- in_ready  out  1  collector can accept a byte.
- in_data  in  8  result byte.
- in_sof  in  1  marks byte 0 (c00 high byte) of a frame.
- out_valid  out  1  out_c00..out_c11 hold a complete frame.
- out_ready  in  1  consumer takes the frame.
- out_c00, out_c01, out_c10, out_c11  out  16 each  signed results, {high byte, low byte}.
- frame_err  out  1  sticky error flag.
- err_clr  in  1  clears frame_err.

## Operation
- A byte is accepted on a cycle with in_valid && in_ready.
- 3-bit byte index idx, 0..7. An accepted byte is written to staging slot idx, then idx increments. Even idx is the high byte, odd idx the low byte. Word order is c00, c01, c10, c11.
- Staging state machine:
  - COLLECT: in_ready=1.
  - FULL: in_ready=0.
- Transitions out of COLLECT on acceptance of byte 7:
  - If the output register is empty, or out_valid && out_ready in the same cycle: staging moves to the output register, out_valid=1 next cycle, idx wraps to 0, and the machine stays in COLLECT.
  - Otherwise: go to FULL.
- FULL: on out_valid && out_ready, the output register loads from staging, out_valid stays 1, the machine returns to COLLECT and idx=0.
- Output register: out_valid is cleared by out_ready only when no new frame is transferred in that same cycle.
- Resync: an accepted byte with in_sof=1 while idx!=0 discards the partial frame, sets frame_err, stores the byte as byte 0 and sets idx=1.
- REQUIRE_SOF=1 and idx==0 and an accepted byte with in_sof=0: the byte is discarded, frame_err is set, and idx stays 0.
- frame_err: a set event in the same cycle as err_clr wins, so frame_err stays 1.
- No arithmetic on the data. Bytes are concatenated verbatim, and sign is carried by bit 15.

## Timing
- Reset values (async assert, sync-released deassert internally):
  - idx=0, state COLLECT.
  - in_ready=1 after reset release.
  - out_valid=0.
  - out_c00..out_c11 = 16'h0000.
  - frame_err=0.
  - Staging cleared.
- Latency: byte 7 accepted at edge N leads to out_valid=1 and the data visible after edge N, with an empty output path.
- Throughput: one byte per cycle sustained when out_ready=1. No bubble between frames.
- in_ready is a registered function of state only. It does not depend combinationally on in_valid or out_ready.
- out_c* are stable while out_valid && !out_ready.
- Reset mid-frame: the partial frame and any held output are lost, and no out_valid pulse occurs.

## Structure
- Shared package tpu_pkg holds:
  - RESULT_W=16.
  - NUM_RESULTS=4.
  - BYTES_PER_FRAME=8.
  - The byte-order constants (HI=0, LO=1 within a word).
  - The staging state enum {ST_COLLECT, ST_FULL}.
- One sub-module, result_out_reg: the output register with valid/ready and load-from-staging. The top level holds idx, staging and the SOF/error logic.

## Test plan
- Frame 12 34 FF FE 00 05 80 00 with SOF on byte 0 and out_ready=1 → one cycle after byte 7: out_c00=16'h1234, out_c01=-2, out_c10=5, out_c11=-32768, out_valid=1.
- Two back-to-back frames with out_ready=0 → the first is held. The second completes, in_ready=0 (FULL), and the remaining input stalls. Raising out_ready for one cycle delivers frame 2 and in_ready=1 the next cycle.
- in_sof at idx=3, then 8 clean bytes → frame_err=1 and the output equals the second frame only. err_clr for one cycle → frame_err=0.
- REQUIRE_SOF=1 with the first byte sent without SOF → byte dropped, frame_err=1, idx stays 0. REQUIRE_SOF=0, same stimulus → accepted, no error.
- rst_n asserted after byte 5 → out_valid=0, out_c*=0 and in_ready=1 after release. A following full frame decodes correctly.
- err_clr and a resync error in the same cycle → frame_err remains 1.
